// File: rtl/axi_mem_responder.sv
// AXI4-style INCR-burst memory responder: independent write (AW/W/B) and read (AR/R)
// engines sharing one byte-writable word memory with combinational read.
module axi_mem_responder #(
  parameter int C_ADDR_WIDTH     = 64,
  parameter int C_DATA_WIDTH     = 128,
  parameter int C_MEM_WORDS_LOG2 = 10
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                      s_axi_rlast,
  output logic                      wlast_err
);

  localparam int NB       = C_DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(NB);
  localparam int IDX_W    = C_MEM_WORDS_LOG2;
  localparam int DEPTH    = 1 << IDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t         w_state_reg, w_state_next;
  logic [IDX_W-1:0] w_idx_reg;
  logic [7:0]       w_len_reg;
  logic [7:0]       w_cnt_reg;
  logic             wlast_err_reg;

  r_state_t         r_state_reg, r_state_next;
  logic [IDX_W-1:0] r_idx_reg;
  logic [7:0]       r_len_reg;
  logic [7:0]       r_cnt_reg;

  logic             w_last_beat;
  logic             r_last_beat;
  logic             aw_fire, w_fire, ar_fire, r_fire;
  logic [IDX_W-1:0] aw_idx, ar_idx;

  // Only the word-index bits of the addresses matter; the rest are folded away here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign aw_idx      = s_axi_awaddr[BYTE_LSB +: IDX_W];
  assign ar_idx      = s_axi_araddr[BYTE_LSB +: IDX_W];
  assign w_last_beat = (w_cnt_reg == w_len_reg);
  assign r_last_beat = (r_cnt_reg == r_len_reg);

  assign aw_fire = s_axi_awvalid & s_axi_awready & ~areset;
  assign w_fire  = s_axi_wvalid  & s_axi_wready;
  assign ar_fire = s_axi_arvalid & s_axi_arready & ~areset;
  assign r_fire  = s_axi_rvalid  & s_axi_rready;

  assign wlast_err = wlast_err_reg & ~areset;

  // Write channel control; reset overrides outputs so they read as idle during reset.
  always_comb begin
    w_state_next  = w_state_reg;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_state_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_last_beat) w_state_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
    if (areset) begin
      w_state_next  = W_IDLE;
      s_axi_awready = 1'b1;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      w_state_reg   <= W_IDLE;
      wlast_err_reg <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      if (aw_fire) begin
        w_idx_reg <= aw_idx;
        w_len_reg <= s_axi_awlen;
        w_cnt_reg <= 8'd0;
      end
      if (w_fire) begin
        w_idx_reg <= w_idx_reg + IDX_W'(1);
        w_cnt_reg <= w_cnt_reg + 8'd1;
        // Beat count decides the burst end; WLAST is only audited.
        if (s_axi_wlast != w_last_beat) wlast_err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    r_state_next  = r_state_reg;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) r_state_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = r_last_beat;
        if (s_axi_rready && r_last_beat) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
    if (areset) begin
      r_state_next  = R_IDLE;
      s_axi_arready = 1'b1;
      s_axi_rvalid  = 1'b0;
      s_axi_rlast   = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_state_reg <= R_IDLE;
    end else begin
      r_state_reg <= r_state_next;
      if (ar_fire) begin
        r_idx_reg <= ar_idx;
        r_len_reg <= s_axi_arlen;
        r_cnt_reg <= 8'd0;
      end
      if (r_fire) begin
        r_idx_reg <= r_idx_reg + IDX_W'(1);
        r_cnt_reg <= r_cnt_reg + 8'd1;
      end
    end
  end

  // One memory per byte lane so each strobe bit is a plain lane write enable.
  // Contents are deliberately not reset; a mid-burst reset keeps written words.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge ap_clk) begin
        if (w_fire && s_axi_wstrb[gi]) lane_mem[w_idx_reg] <= s_axi_wdata[gi*8 +: 8];
      end

      assign s_axi_rdata[gi*8 +: 8] = lane_mem[r_idx_reg];
    end
  endgenerate

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized scoreboard bench for axi_mem_responder: a word-array reference model
// predicts every read beat and B response; a negedge monitor pops and compares.
module tb_axi_mem_responder;

  localparam int AW    = 64;
  localparam int DW    = 128;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1024;

  logic          ap_clk, areset;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast, wlast_err;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [DW-1:0] wdata, rdata;
  logic [NB-1:0] wstrb;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } rexp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rexp_t         rq[$];
  int            b_expect = 0;
  int            r_pops   = 0;
  int            b_pops   = 0;
  int            checks   = 0;
  int            failures = 0;

  axi_mem_responder #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MEM_WORDS_LOG2(10)
  ) dut (
    .ap_clk(ap_clk), .areset(areset),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .wlast_err(wlast_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: while a beat is presented it must match the head of the queue.
  always @(negedge ap_clk) begin
    if (!areset) begin
      if (rvalid) begin
        if (rq.size() == 0) begin
          chk("r_unexpected_rvalid", rvalid, 0);
        end else begin
          chk("rdata", rdata, rq[0].data);
          chk("rlast", rlast, rq[0].last);
          if (rready) begin
            rq.delete(0);
            r_pops++;
            $display("R beat done pops=%0d data=%h last=%0d", r_pops, rdata, rlast);
          end
        end
      end
      if (bvalid && bready) begin
        if (b_expect == 0) begin
          chk("b_unexpected_bvalid", bvalid, 0);
        end else begin
          b_expect--;
          b_pops++;
          $display("B response done count=%0d", b_pops);
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: random data/strb; 1: data=beat index, full strb; 2: fixed data/strb; 3: random data, full strb
  task automatic do_write(input int idx, input int len, input int wlast_at, input int bstall,
                          input int mode, input logic [DW-1:0] fdata, input logic [NB-1:0] fstrb);
    int t;
    logic [DW-1:0] d;
    logic [NB-1:0] s;
    @(posedge ap_clk); #1;
    awvalid = 1'b1;
    awaddr  = {32'($urandom), 18'($urandom), 14'(idx * 16 + int'($urandom_range(0, 15)))};
    awlen   = 8'(len);
    t = 0;
    @(negedge ap_clk);
    while (!awready && t < 50) begin @(negedge ap_clk); t++; end
    if (!awready) chk("aw_timeout", awready, 1);
    @(posedge ap_clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      case (mode)
        1:       begin d = DW'(i);  s = '1;   end
        2:       begin d = fdata;   s = fstrb; end
        3:       begin d = rnd128(); s = '1;  end
        default: begin d = rnd128(); s = NB'({$urandom, $urandom}); end
      endcase
      wvalid = 1'b1; wdata = d; wstrb = s;
      wlast  = (wlast_at < 0) ? (i == len) : (i == wlast_at);
      for (int b = 0; b < NB; b++)
        if (s[b]) ref_mem[(idx + i) % DEPTH][b*8 +: 8] = d[b*8 +: 8];
      t = 0;
      @(negedge ap_clk);
      while (!wready && t < 50) begin @(negedge ap_clk); t++; end
      if (!wready) chk("w_timeout", wready, 1);
      @(posedge ap_clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    b_expect++;
    for (int c = 0; c < bstall; c++) begin
      @(negedge ap_clk);
      chk("bvalid_held", bvalid, 1);
      @(posedge ap_clk); #1;
    end
    bready = 1'b1;
    t = 0;
    @(negedge ap_clk);
    while (!bvalid && t < 50) begin @(negedge ap_clk); t++; end
    if (!bvalid) chk("b_timeout", bvalid, 1);
    @(posedge ap_clk); #1;
    bready = 1'b0;
    $display("W burst idx=%0d len=%0d mode=%0d issued", idx, len, mode);
  endtask

  function automatic logic rr_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: rready always 1; 1: 1,0,0,1 pattern; 2: random rready
  task automatic do_read(input int idx, input int len, input int mode);
    int t, cyc, target;
    for (int i = 0; i <= len; i++) rq.push_back('{ref_mem[(idx + i) % DEPTH], i == len});
    target = r_pops + len + 1;
    @(posedge ap_clk); #1;
    arvalid = 1'b1;
    araddr  = {32'($urandom), 18'($urandom), 14'(idx * 16 + int'($urandom_range(0, 15)))};
    arlen   = 8'(len);
    t = 0;
    @(negedge ap_clk);
    while (!arready && t < 50) begin @(negedge ap_clk); t++; end
    if (!arready) chk("ar_timeout", arready, 1);
    @(posedge ap_clk); #1;
    arvalid = 1'b0;
    cyc = 0;
    rready = rr_pat(mode, cyc);
    @(negedge ap_clk);
    chk("r_first_latency", rvalid, 1);
    while (r_pops < target && cyc < 1000) begin
      @(posedge ap_clk); #1;
      cyc++;
      rready = rr_pat(mode, cyc);
    end
    rready = 1'b0;
    if (r_pops < target) chk("r_timeout", 32'(r_pops), 32'(target));
    if (mode == 0) chk("r_throughput", 32'(cyc), 32'(len + 1));
    @(negedge ap_clk);
    chk("r_idle_after_last", rvalid, 0);
    $display("R burst idx=%0d len=%0d mode=%0d cycles=%0d", idx, len, mode, cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rlast"}, rlast, 0);
    chk({tag, "_wlast_err"}, wlast_err, 0);
  endtask

  initial begin
    int b0, idx, len;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    areset = 1'b1;
    awvalid = 0; awaddr = '0; awlen = '0; wvalid = 0; wdata = '0; wstrb = '0; wlast = 0;
    bready = 0; arvalid = 0; araddr = '0; arlen = '0; rready = 0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk_reset_outputs("por");
    @(posedge ap_clk); #1;
    areset = 1'b0;

    // Fill every word so no read touches undefined contents.
    for (int k = 0; k < 4; k++) do_write(k * 256, 255, -1, 0, 3, '0, '0);

    // 16-beat incrementing burst, one B, read back in order.
    b0 = b_pops;
    do_write(0, 15, -1, 0, 1, '0, '0);
    chk("one_b_response", 32'(b_pops), 32'(b0 + 1));
    do_read(0, 15, 0);
    @(negedge ap_clk);
    chk("wlast_err_clean", wlast_err, 0);

    // Byte-strobe merge on word 3.
    do_write(3, 0, -1, 0, 2, '1, '1);
    do_write(3, 0, -1, 0, 2, '0, 16'h000F);
    do_read(3, 0, 0);

    // Index wrap at the top of memory.
    do_write(1022, 3, -1, 0, 3, '0, '0);
    do_read(0, 1, 0);
    do_read(1022, 3, 2);

    // Stalled read concurrent with a write whose B is held off.
    fork
      do_write(100, 7, -1, 5, 0, '0, '0);
      do_read(500, 7, 1);
    join

    for (int n = 0; n < 25; n++) begin
      idx = int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(0, 15));
      do_write(idx, len, -1, int'($urandom_range(0, 3)), 0, '0, '0);
      do_read((idx + int'($urandom_range(0, 4))) % DEPTH, int'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)));
    end
    @(negedge ap_clk);
    chk("wlast_err_still_clean", wlast_err, 0);

    // Early WLAST: all 4 beats still taken, error flag sticks.
    b0 = b_pops;
    do_write(40, 3, 1, 0, 3, '0, '0);
    chk("early_wlast_one_b", 32'(b_pops), 32'(b0 + 1));
    @(negedge ap_clk);
    chk("wlast_err_set", wlast_err, 1);
    do_read(40, 3, 0);
    do_write(60, 1, -1, 0, 0, '0, '0);
    @(negedge ap_clk);
    chk("wlast_err_sticky", wlast_err, 1);

    // Reset during beat 2 of an 8-beat read.
    for (int i = 0; i <= 7; i++) rq.push_back('{ref_mem[(200 + i) % DEPTH], i == 7});
    @(posedge ap_clk); #1;
    arvalid = 1'b1; araddr = 64'(200 * 16); arlen = 8'd7;
    @(posedge ap_clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge ap_clk);
    @(posedge ap_clk); #1;
    areset = 1'b1;
    @(negedge ap_clk);
    chk_reset_outputs("mid_read_reset");
    @(posedge ap_clk); #1;
    areset = 1'b0; rready = 1'b0;
    chk("aborted_beats", 32'(rq.size()), 32'd6);
    rq.delete();
    @(negedge ap_clk);
    chk("post_reset_rvalid", rvalid, 0);
    chk("post_reset_arready", arready, 1);
    chk("post_reset_wlast_err", wlast_err, 0);
    do_read(200, 7, 0);
    do_read(40, 3, 2);

    repeat (3) @(posedge ap_clk);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("b_drained", 32'(b_expect), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 The block SHALL take parameter C_ADDR_WIDTH, default 64, as the AXI address width in bits.
REQ-002 The block SHALL take parameter C_DATA_WIDTH, default 128, as the AXI data width in bits; legal values are powers of two from 32 to 512.
REQ-003 The block SHALL take parameter C_MEM_WORDS_LOG2, default 10, as log2 of the internal memory depth in C_DATA_WIDTH words.
REQ-004 The block SHALL have port ap_clk, input, 1 bit: the clock; all logic is on the rising edge.
REQ-005 The block SHALL have port areset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the following write-address ports: s_axi_awvalid in 1; s_axi_awready out 1; s_axi_awaddr in C_ADDR_WIDTH; s_axi_awlen in 8.
REQ-007 The block SHALL have the following write-data ports: s_axi_wvalid in 1; s_axi_wready out 1; s_axi_wdata in C_DATA_WIDTH; s_axi_wstrb in C_DATA_WIDTH/8; s_axi_wlast in 1.
REQ-008 The block SHALL have the following write-response ports: s_axi_bvalid out 1; s_axi_bready in 1.
REQ-009 The block SHALL have the following read-address ports: s_axi_arvalid in 1; s_axi_arready out 1; s_axi_araddr in C_ADDR_WIDTH; s_axi_arlen in 8.
REQ-010 The block SHALL have the following read-data ports: s_axi_rvalid out 1; s_axi_rready in 1; s_axi_rdata out C_DATA_WIDTH; s_axi_rlast out 1.
REQ-011 The block SHALL have port wlast_err, output, 1 bit: sticky flag for a WLAST/beat-count mismatch.

Function
REQ-012 The block SHALL compute word index = (addr >> log2(C_DATA_WIDTH/8)) mod 2^C_MEM_WORDS_LOG2, ignoring low byte-offset bits; a burst SHALL be INCR only.
REQ-013 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP, and SHALL be independent of the read FSM.
REQ-014 In W_IDLE: awready=1 and wready=0; on awvalid the block SHALL latch the index and awlen, clear the beat count, and go to W_DATA next cycle.
REQ-015 In W_DATA: wready=1 and awready=0; each wvalid&wready beat SHALL write the bytes whose wstrb bit is 1 to mem[index], then increment the index (wrapping modulo depth) and the beat count.
REQ-016 The burst SHALL end on beat count = awlen+1 (awlen=0 means 1 beat), regardless of wlast; the FSM SHALL then go to W_RESP.
REQ-017 wlast=1 on a non-final beat, or wlast=0 on the final beat, SHALL set wlast_err to 1; it stays 1 until reset.
REQ-018 In W_RESP: bvalid=1; on bready the FSM SHALL return to W_IDLE next cycle; bvalid SHALL be held until bready.
REQ-019 Minimum write-transaction cycles SHALL be 1 (AW) + (awlen+1) (W) + 1 (B).
REQ-020 The read FSM SHALL have states R_IDLE and R_DATA.
REQ-021 In R_IDLE: arready=1 and rvalid=0; on arvalid the block SHALL latch the index and arlen, and go to R_DATA next cycle.
REQ-022 In R_DATA: rvalid=1; rdata SHALL equal mem[read index] read combinationally; rlast=1 only when beat count = arlen.
REQ-023 On rvalid&rready the block SHALL advance the index (wrapping) and the count; after the final beat it SHALL return to R_IDLE.
REQ-024 While rready=0, rdata and rlast SHALL be held stable, except that rdata follows a concurrent write to that same word.
REQ-025 The first read beat SHALL be valid 1 cycle after AR acceptance; with rready held at 1, throughput SHALL be 1 beat per cycle.
REQ-026 On a same-cycle write beat and read beat to the same word, the read SHALL return the pre-write value; the new value is visible from the next cycle.
REQ-027 AW and AR accepted in the same cycle SHALL both proceed concurrently, with no ordering between channels.
REQ-028 The memory SHALL not be reset, and its contents are undefined until written.

Reset
REQ-029 While areset=1, the block SHALL drive: both FSMs in their IDLE state; awready=1; arready=1; wready=0; bvalid=0; rvalid=0; rlast=0; wlast_err=0; rdata don't-care.
REQ-030 A reset asserted mid-burst SHALL abort the burst with no B or R response, and words already written SHALL remain in memory.

Verification
REQ-031 Scenario: AW addr 0x0 awlen=15, W beats data=i with wlast on beat 15, then AR addr 0x0 arlen=15 -> exactly one bvalid; rdata=0..15 in order; rlast only on beat 15; wlast_err=0.
REQ-032 Scenario: write word 3 with 0xFFFF..FF, then a write to word 3 with data 0 and wstrb=0x000F -> a read of word 3 returns 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000.
REQ-033 Scenario: C_MEM_WORDS_LOG2=10, burst at index 1022 awlen=3, read index 0 arlen=1 -> data lands in words 1022, 1023, 0, 1; read returns beats 2 and 3.
REQ-034 Scenario: 8-beat read with rready toggled 1,0,0,1 repeating, and bready held at 0 for 5 cycles -> no beat lost or duplicated, rdata stable while stalled, bvalid held 5 cycles.
REQ-035 Scenario: awlen=3 with wlast on beat 1 -> 4 beats accepted, one B response, wlast_err=1 until areset.
REQ-036 Scenario: areset pulsed during beat 2 of an 8-beat read -> next cycle rvalid=0 and arready=1; a new AR is then served correctly.
